add_rq_seq: RTL and testbench
=============================

// Module: add_rq_seq
// PURPOSE
//  Sequencer for the shared 13-bit mod-2^13 coefficient adder used in the Encaps
//  AddUnpackRq0 unit. On start, streams N coefficient pairs from two
//  coefficient RAMs (A, B) through the external combinational adder and writes
//  c[i] = (a[i] + b[i]) mod 2^W to the result RAM, one coefficient per cycle,
//  with a global hold (stall) input. The adder itself is not inside this block.
// PARAMETERS
//  N   701  number of coefficients per polynomial (NTRU-HRSS n); legal range 1..2^AW
//  W   13   coefficient width (q = 2^W = 8192)
//  AW  10   address width; 2^AW >= N
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   1-cycle request; accepted only in IDLE
//  hold       in   1   stall: freezes all state while high
//  busy       out  1   high from the cycle after start is accepted until done
//  done       out  1   1-cycle pulse after the last write
//  rd_en      out  1   read strobe to A and B RAMs
//  rd_addr    out  AW  coefficient index read from A and B (shared)
//  a_rdata    in   W   A RAM data, valid 1 cycle after rd_en; held while rd_en=0
//  b_rdata    in   W   B RAM data, same timing as a_rdata
//  add_x1     out  W   adder operand 1 (registered)
//  add_x2     out  W   adder operand 2 (registered)
//  add_out    in   W   adder sum (combinational from add_x1/add_x2)
//  wr_en      out  1   write strobe to result RAM
//  wr_addr    out  AW  result index
//  wr_data    out  W   = add_out when wr_en=1
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busy, done, rd_en, wr_en = 0; rd_addr,
//   wr_addr, add_x1, add_x2 = 0; pipeline valid bits cleared. Asserting rst_n=0
//   mid-operation aborts immediately; no further writes; no done pulse.
//  FSM: IDLE -> RUN on start (hold=0). RUN issues reads; after index N-1 is
//   issued -> DRAIN. DRAIN waits until the last write has occurred -> DONE.
//   DONE asserts done for exactly 1 cycle -> IDLE. busy=1 in RUN, DRAIN, DONE.
//  start while not IDLE is ignored (no restart, no queueing).
//  Pipeline (no hold): cycle k: rd_en=1, rd_addr=i. Cycle k+1: a/b_rdata valid;
//   registered into add_x1/add_x2 at end of k+1. Cycle k+2: wr_en=1,
//   wr_addr=i, wr_data=add_out. Read-to-write latency 2 cycles; throughput 1/cycle.
//  Run length: start sampled at edge 0 -> reads in cycles 1..N, writes in cycles
//   3..N+2, done in cycle N+3, busy low again in cycle N+4.
//  Arithmetic: sum truncated to W bits (mod 2^W); carry out discarded; no
//   saturation. Indices 0..N-1 in increasing order, each written exactly once.
//  hold=1: rd_en=0, wr_en=0, no register (FSM, address, operand, valid) updates;
//   done pulse deferred if hold hits in DONE. RAMs must keep rdata stable while
//   rd_en=0, so a read issued just before hold is captured after release.
//  hold in IDLE: start is ignored while hold=1.
//  N=1: single read, single write, done 3 cycles after the read.
//  Address counters never exceed N-1; no wrap beyond N.
// TESTING
//  1. N=701, a[i]=8191, b[i]=1 all i -> 701 writes, every wr_data=0 (wrap),
//     wr_addr 0..700 in order, done exactly once, cycle N+3 after start.
//  2. Random a,b (seeded) vs model (a+b)&0x1FFF -> all 701 results match;
//     wr_en high 701 consecutive cycles.
//  3. Random hold (~30% duty) during RUN/DRAIN/DONE -> same results as (2), no
//     duplicate/missing addresses, rd_en=wr_en=0 on every hold cycle.
//  4. start pulsed again at cycles 5 and N+2 of a run -> ignored; one done only.
//  5. rst_n low at write index 300 -> all outputs 0 immediately, no done; new
//     start then completes full correct run.
//  6. N=1 build, a[0]=4096, b[0]=4097 -> one write wr_addr=0, wr_data=1; done at
//     cycle 4 after start.

Source files
------------

// File: rtl/add_rq_seq.sv
// add_rq_seq: sequencer for the shared W-bit mod-2^W coefficient adder.
// Streams N coefficient pairs from the A/B RAMs through an external
// combinational adder and writes c[i] = a[i] + b[i] (mod 2^W) to the result
// RAM, one coefficient per cycle, with a global stall (hold).
module add_rq_seq #(
  parameter int N  = 701,
  parameter int W  = 13,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  a_rdata,
  input  logic [W-1:0]  b_rdata,
  output logic [W-1:0]  add_x1,
  output logic [W-1:0]  add_x2,
  input  logic [W-1:0]  add_out,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t          state_q, state_d;
  logic            vld_p1;   // RAM data for addr_p1 is on a/b_rdata
  logic [AW-1:0]   addr_p1;
  logic            vld_p2;   // add_x1/add_x2 hold operands for wr_addr

  // Next-state logic; hold freezes the FSM in place.
  always_comb begin
    state_d = state_q;
    if (!hold) begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (rd_addr == LAST) state_d = DRAIN;
        // Last write happens this cycle when the operand stage is full
        // and nothing is left in the read stage behind it.
        DRAIN:   if (vld_p2 && !vld_p1) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes are gated by hold so no RAM access happens during a stall.
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE) && !hold;
    rd_en   = (state_q == RUN) && !hold;
    wr_en   = vld_p2 && !hold;
    wr_data = wr_en ? add_out : '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- stage p0: read address issue ----
  // Read address counter; restarts at 0 on an accepted start, stops at N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
    end else if (!hold) begin
      if (state_q == IDLE && start)
        rd_addr <= '0;
      else if (state_q == RUN && rd_addr != LAST)
        rd_addr <= rd_addr + AW'(1);
    end
  end

  // ---- stage p1: RAM data returning ----
  // Tracks which read is in flight so its data is captured the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
    end else if (!hold) begin
      vld_p1  <= (state_q == RUN);
      addr_p1 <= rd_addr;
    end
  end

  // ---- stage p2: registered adder operands / write ----
  // Captures RAM data into the adder operands; the sum is written next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      add_x1  <= '0;
      add_x2  <= '0;
      wr_addr <= '0;
    end else if (!hold) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        add_x1  <= a_rdata;
        add_x2  <= b_rdata;
        wr_addr <= addr_p1;
      end
    end
  end

endmodule

// File: tb/tb_add_rq_seq.sv
// Testbench for add_rq_seq: RAM and adder models around the sequencer,
// table-driven and randomized runs against a mod-2^W reference model.
module tb_add_rq_seq;

  localparam int N  = 701;
  localparam int W  = 13;
  localparam int AW = 10;
  localparam int Q  = 8192;

  logic          clk;
  logic          rst_n;
  logic          start, hold;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  a_rdata, b_rdata, add_x1, add_x2, add_out, wr_data;

  logic          start_s, hold_s;
  logic          busy_s, done_s, rd_en_s, wr_en_s;
  logic [AW-1:0] rd_addr_s, wr_addr_s;
  logic [W-1:0]  a_rdata_s, b_rdata_s, add_x1_s, add_x2_s, add_out_s, wr_data_s;

  int n_tests;
  int n_fail;
  int cyc;

  logic [W-1:0] a_mem [N];
  logic [W-1:0] b_mem [N];
  int           exp_mem [N];
  logic [W-1:0] a_mem_s, b_mem_s;

  typedef struct { int a; int b; int sum; } vec_t;
  vec_t tbl [8];

  add_rq_seq #(.N(N), .W(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .add_x1(add_x1), .add_x2(add_x2),
    .add_out(add_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  add_rq_seq #(.N(1), .W(W), .AW(AW)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .hold(hold_s),
    .busy(busy_s), .done(done_s), .rd_en(rd_en_s), .rd_addr(rd_addr_s),
    .a_rdata(a_rdata_s), .b_rdata(b_rdata_s), .add_x1(add_x1_s), .add_x2(add_x2_s),
    .add_out(add_out_s), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAMs: data updates only on a read strobe, held otherwise.
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[rd_addr];
      b_rdata <= b_mem[rd_addr];
    end
    if (rd_en_s) begin
      a_rdata_s <= a_mem_s;
      b_rdata_s <= b_mem_s;
    end
  end

  // External combinational adders (mod 2^W by truncation).
  assign add_out   = add_x1 + add_x2;
  assign add_out_s = add_x1_s + add_x2_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic load_const();
    for (int i = 0; i < N; i++) begin
      a_mem[i] = 13'd8191; b_mem[i] = 13'd1; exp_mem[i] = 0;
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) begin
      a_mem[i]   = W'(tbl[i % 8].a);
      b_mem[i]   = W'(tbl[i % 8].b);
      exp_mem[i] = tbl[i % 8].sum;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++) begin
      int a, b;
      a = int'($urandom_range(Q - 1));
      b = int'($urandom_range(Q - 1));
      a_mem[i]   = W'(a);
      b_mem[i]   = W'(b);
      exp_mem[i] = (a + b) % Q;
    end
  endtask

  // One complete run. Cycle c is the clock period following edge c-1,
  // where edge 0 is the edge that samples start.
  task automatic run(input int hold_pct, input bit restart, input int abort_at,
                     input bit check_timing);
    int  t0, cn, wr_cnt, exp_addr, done_cnt, done_cyc, first_wr, last_wr;
    bit  finished, prev_done, aborted;
    wr_cnt = 0; exp_addr = 0; done_cnt = 0; done_cyc = -1;
    first_wr = -1; last_wr = -1;
    finished = 0; prev_done = 0; aborted = 0;
    @(posedge clk); #1;
    hold = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 4 * N + 40; k++) begin
      cn = cyc - t0 + 1;
      start = restart && (cn == 5 || cn == N + 2);
      hold  = (hold_pct > 0) && (int'($urandom_range(99)) < hold_pct);
      if (abort_at >= 0 && exp_addr == abort_at) begin
        hold  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);     chk("abort_done", done, 0);
        chk("abort_rd_en", rd_en, 0);   chk("abort_wr_en", wr_en, 0);
        chk("abort_rd_addr", rd_addr, 0); chk("abort_wr_addr", wr_addr, 0);
        chk("abort_x1", add_x1, 0);     chk("abort_x2", add_x2, 0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_write", wr_en, 0);
          chk("abort_no_done", done, 0);
        end
        @(posedge clk); #1;
        rst_n   = 1'b1;
        aborted = 1;
        break;
      end
      @(negedge clk);
      if (prev_done) begin
        chk("busy_after_done", busy, 0);
        finished = 1;
        break;
      end
      if (wr_en) begin
        if (first_wr < 0) first_wr = cn;
        last_wr = cn;
        if (exp_addr < N) begin
          chk("wr_addr", wr_addr, exp_addr);
          chk("wr_data", wr_data, exp_mem[exp_addr]);
        end else begin
          chk("extra_write", wr_addr, 32'hFFFF_FFFF);
        end
        wr_cnt++;
        exp_addr++;
      end
      if (hold) begin
        chk("hold_rd_en", rd_en, 0);
        chk("hold_wr_en", wr_en, 0);
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cn;
        prev_done = 1;
      end
      @(posedge clk); #1;
    end
    hold  = 1'b0;
    start = 1'b0;
    if (aborted) begin
      chk("abort_wr_cnt", wr_cnt, abort_at);
      chk("abort_done_cnt", done_cnt, 0);
      repeat (5) begin
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
      end
    end else begin
      chk("run_finished", finished, 1);
      chk("wr_cnt", wr_cnt, N);
      chk("done_cnt", done_cnt, 1);
      if (check_timing) begin
        chk("done_cycle", done_cyc, N + 3);
        chk("first_wr_cycle", first_wr, 3);
        chk("last_wr_cycle", last_wr, N + 2);
      end
      repeat (3) begin
        @(negedge clk);
        chk("idle_after_run", busy, 0);
        chk("no_second_done", done, 0);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    void'($urandom(32'd20240611));
    tbl[0] = '{8191, 1,    0};
    tbl[1] = '{4096, 4097, 1};
    tbl[2] = '{0,    0,    0};
    tbl[3] = '{8191, 8191, 8190};
    tbl[4] = '{1234, 5678, 6912};
    tbl[5] = '{5000, 5000, 1808};
    tbl[6] = '{4095, 4096, 8191};
    tbl[7] = '{7,    8185, 0};

    rst_n = 1'b0; start = 1'b0; hold = 1'b0;
    start_s = 1'b0; hold_s = 1'b0;
    a_mem_s = 13'd4096; b_mem_s = 13'd4097;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);     chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0); chk("rst_wr_addr", wr_addr, 0);
    chk("rst_x1", add_x1, 0);       chk("rst_x2", add_x2, 0);
    chk("rst_busy_n1", busy_s, 0);
    rst_n = 1'b1;

    // Start while hold is high is ignored in IDLE.
    @(posedge clk); #1;
    hold = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    hold = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_under_hold", busy, 0);

    load_const();  run(0, 0, -1, 1);   // all sums wrap to 0
    load_table();  run(0, 0, -1, 1);   // boundary sums from the table
    load_random(); run(0, 0, -1, 1);   // random operands, no stall
    load_random(); run(30, 0, -1, 0);  // random operands, random stall
    load_random(); run(0, 1, -1, 1);   // extra starts mid-run are ignored
    load_random(); run(0, 0, 300, 0);  // abort via reset at write 300
    run(0, 0, -1, 1);                  // clean run after the abort

    // Single-coefficient instance.
    @(posedge clk); #1;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("n1_rd_en", rd_en_s, (c == 1));
      chk("n1_wr_en", wr_en_s, (c == 3));
      chk("n1_done", done_s, (c == 4));
      chk("n1_busy", busy_s, (c <= 4));
      if (c == 3) begin
        chk("n1_wr_addr", wr_addr_s, 0);
        chk("n1_wr_data", wr_data_s, 1);
      end
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
